// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core types: decoded control bundle and its NOP value.
package core_pkg;

  typedef struct packed {
    logic       write_en_rf;
    logic       imm_src;
    logic [4:0] alu_op;
    logic       write_en_dmem;
    logic [2:0] load_type;
    logic [1:0] store_type;
    logic       fence_en;
    logic       alu_rd2_select;
    logic       branch_en;
    logic       jal_en;
    logic       jalr_en;
    logic       data_read;
    logic       auipc_en;
    logic       lui_en;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// rtl/id_ex_stage_hazard_detect.sv - load-use hazard detection and upstream stall request.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_data_read,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic              id_valid,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              flush,
  input  logic              flush_pending,
  input  logic              ex_stall,
  output logic              load_use,
  output logic              stall
);

  logic ex_is_load;
  logic rs1_hit;
  logic rs2_hit;

  // A load to x0 never produces a value anyone can depend on.
  assign ex_is_load = ex_valid && ex_data_read && (ex_rd_addr != '0);
  assign rs1_hit    = id_uses_rs1 && (id_rs1_addr == ex_rd_addr);
  assign rs2_hit    = id_uses_rs2 && (id_rs2_addr == ex_rd_addr);
  assign load_use   = ex_is_load && id_valid && (rs1_hit || rs2_hit);

  // A flush (now or owed) kills the dependent instruction, so no need to hold it.
  assign stall = ex_stall || (load_use && !flush && !flush_pending);

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble, flush and downstream stall.
// Optional ID_EX_PERF_CNT_EN adds load-use stall and flush bubble counters.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  ctrl_t             id_ctrl_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [XLEN-1:0]   id_rs1_data_i,
  input  logic [XLEN-1:0]   id_rs2_data_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic [REG_AW-1:0] id_rs1_addr_i,
  input  logic [REG_AW-1:0] id_rs2_addr_i,
  input  logic [REG_AW-1:0] id_rd_addr_i,
  input  logic              id_uses_rs1_i,
  input  logic              id_uses_rs2_i,
  input  logic              flush_i,
  input  logic              ex_stall_i,
  output logic              ex_valid_o,
  output ctrl_t             ex_ctrl_o,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [XLEN-1:0]   ex_rs1_data_o,
  output logic [XLEN-1:0]   ex_rs2_data_o,
  output logic [XLEN-1:0]   ex_imm_o,
  output logic [REG_AW-1:0] ex_rs1_addr_o,
  output logic [REG_AW-1:0] ex_rs2_addr_o,
  output logic [REG_AW-1:0] ex_rd_addr_o,
  output logic              stall_o
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  logic load_use;
  logic flush_pending;
  logic do_flush;
  logic do_bubble;
  logic do_capture;

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard_detect (
    .ex_valid      (ex_valid_o),
    .ex_data_read  (ex_ctrl_o.data_read),
    .ex_rd_addr    (ex_rd_addr_o),
    .id_valid      (id_valid_i),
    .id_uses_rs1   (id_uses_rs1_i),
    .id_uses_rs2   (id_uses_rs2_i),
    .id_rs1_addr   (id_rs1_addr_i),
    .id_rs2_addr   (id_rs2_addr_i),
    .flush         (flush_i),
    .flush_pending (flush_pending),
    .ex_stall      (ex_stall_i),
    .load_use      (load_use),
    .stall         (stall_o)
  );

  // Priority: downstream stall, then flush, then load-use, then normal capture.
  assign do_flush   = !ex_stall_i && (flush_i || flush_pending);
  assign do_bubble  = !ex_stall_i && !do_flush && load_use;
  assign do_capture = !ex_stall_i && !do_flush && !load_use;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_pending <= 1'b0;
    end else if (ex_stall_i) begin
      if (flush_i) begin
        flush_pending <= 1'b1;
      end
    end else begin
      flush_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_o    <= 1'b0;
      ex_ctrl_o     <= CTRL_NOP;
      ex_pc_o       <= '0;
      ex_rs1_data_o <= '0;
      ex_rs2_data_o <= '0;
      ex_imm_o      <= '0;
      ex_rs1_addr_o <= '0;
      ex_rs2_addr_o <= '0;
      ex_rd_addr_o  <= '0;
    end else if (do_capture) begin
      ex_valid_o    <= id_valid_i;
      ex_ctrl_o     <= id_valid_i ? id_ctrl_i : CTRL_NOP;
      ex_pc_o       <= id_pc_i;
      ex_rs1_data_o <= id_rs1_data_i;
      ex_rs2_data_o <= id_rs2_data_i;
      ex_imm_o      <= id_imm_i;
      ex_rs1_addr_o <= id_rs1_addr_i;
      ex_rs2_addr_o <= id_rs2_addr_i;
      ex_rd_addr_o  <= id_rd_addr_i;
    end else if (do_flush || do_bubble) begin
      // Bubbles also clear the datapath so waveforms stay deterministic.
      ex_valid_o    <= 1'b0;
      ex_ctrl_o     <= CTRL_NOP;
      ex_pc_o       <= '0;
      ex_rs1_data_o <= '0;
      ex_rs2_data_o <= '0;
      ex_imm_o      <= '0;
      ex_rs1_addr_o <= '0;
      ex_rs2_addr_o <= '0;
      ex_rd_addr_o  <= '0;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (do_bubble) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
      if (do_flush) begin
        flush_cnt_o <= flush_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed and randomized checks of id_ex_stage against a behavioural model.
module tb_id_ex_stage;
  import core_pkg::*;

  typedef struct packed {
    logic        valid;
    ctrl_t       ctrl;
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [4:0]  rda;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid_i;
  ctrl_t       id_ctrl_i;
  logic [31:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
  logic        id_uses_rs1_i, id_uses_rs2_i, flush_i, ex_stall_i;
  logic        ex_valid_o;
  ctrl_t       ex_ctrl_o;
  logic [31:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
  logic [4:0]  ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o;
  logic        stall_o;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

  id_ex_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid_i    (id_valid_i),
    .id_ctrl_i     (id_ctrl_i),
    .id_pc_i       (id_pc_i),
    .id_rs1_data_i (id_rs1_data_i),
    .id_rs2_data_i (id_rs2_data_i),
    .id_imm_i      (id_imm_i),
    .id_rs1_addr_i (id_rs1_addr_i),
    .id_rs2_addr_i (id_rs2_addr_i),
    .id_rd_addr_i  (id_rd_addr_i),
    .id_uses_rs1_i (id_uses_rs1_i),
    .id_uses_rs2_i (id_uses_rs2_i),
    .flush_i       (flush_i),
    .ex_stall_i    (ex_stall_i),
    .ex_valid_o    (ex_valid_o),
    .ex_ctrl_o     (ex_ctrl_o),
    .ex_pc_o       (ex_pc_o),
    .ex_rs1_data_o (ex_rs1_data_o),
    .ex_rs2_data_o (ex_rs2_data_o),
    .ex_imm_o      (ex_imm_o),
    .ex_rs1_addr_o (ex_rs1_addr_o),
    .ex_rs2_addr_o (ex_rs2_addr_o),
    .ex_rd_addr_o  (ex_rd_addr_o),
    .stall_o       (stall_o)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .stall_cnt_o   (stall_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int   n_pass = 0;
  int   n_total = 0;
  rec_t m;
  bit   m_pend;
  int unsigned m_scnt, m_fcnt;

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic rec_t dut_rec();
    rec_t r;
    r = {ex_valid_o, ex_ctrl_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
         ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o};
    return r;
  endfunction

  // Model: a dependent consumer of a nonzero-rd load sitting in EX.
  function automatic bit model_load_use();
    bit dep;
    dep = (id_uses_rs1_i && id_rs1_addr_i == m.rda) || (id_uses_rs2_i && id_rs2_addr_i == m.rda);
    return m.valid && m.ctrl.data_read && (m.rda != 0) && id_valid_i && dep;
  endfunction

  function automatic bit model_stall();
    return ex_stall_i || (model_load_use() && !flush_i && !m_pend);
  endfunction

  task automatic model_reset();
    m = '0; m_pend = 0; m_scnt = 0; m_fcnt = 0;
  endtask

  task automatic model_step();
    rec_t nxt;
    bit   lu;
    lu = model_load_use();
    if (ex_stall_i) begin
      if (flush_i) m_pend = 1;
    end else if (flush_i || m_pend) begin
      m = '0; m_pend = 0; m_fcnt++;
    end else if (lu) begin
      m = '0; m_scnt++;
    end else begin
      nxt = {id_valid_i, (id_valid_i ? id_ctrl_i : CTRL_NOP), id_pc_i, id_rs1_data_i,
             id_rs2_data_i, id_imm_i, id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i};
      m = nxt;
    end
  endtask

  task automatic compare_all();
    #1;
    chk("ex_record", 200'(dut_rec()), 200'(m));
    chk("stall_o", 200'(stall_o), 200'(model_stall()));
`ifdef ID_EX_PERF_CNT_EN
    chk("stall_cnt", 200'(stall_cnt_o), 200'(m_scnt));
    chk("flush_cnt", 200'(flush_cnt_o), 200'(m_fcnt));
`endif
  endtask

  task automatic cycle();
    compare_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    id_valid_i = 0; id_ctrl_i = CTRL_NOP; id_pc_i = 0; id_rs1_data_i = 0;
    id_rs2_data_i = 0; id_imm_i = 0; id_rs1_addr_i = 0; id_rs2_addr_i = 0;
    id_rd_addr_i = 0; id_uses_rs1_i = 0; id_uses_rs2_i = 0; flush_i = 0; ex_stall_i = 0;
  endtask

  task automatic instr(input logic [31:0] pc, input ctrl_t c, input logic [4:0] rs1,
                       input logic u1, input logic [4:0] rs2, input logic u2, input logic [4:0] rd);
    id_valid_i = 1; id_ctrl_i = c; id_pc_i = pc; id_rs1_data_i = pc ^ 32'h1111_0000;
    id_rs2_data_i = pc ^ 32'h2222_0000; id_imm_i = pc + 32'd12; id_rs1_addr_i = rs1;
    id_uses_rs1_i = u1; id_rs2_addr_i = rs2; id_uses_rs2_i = u2; id_rd_addr_i = rd;
  endtask

  task automatic rand_inputs();
    id_valid_i    = ($urandom_range(0, 99) < 85);
    id_ctrl_i     = ctrl_t'($urandom);
    id_ctrl_i.data_read = $urandom_range(0, 1);
    id_pc_i       = $urandom; id_rs1_data_i = $urandom;
    id_rs2_data_i = $urandom; id_imm_i = $urandom;
    id_rs1_addr_i = 5'($urandom_range(0, 3));
    id_rs2_addr_i = 5'($urandom_range(0, 3));
    id_rd_addr_i  = 5'($urandom_range(0, 3));
    id_uses_rs1_i = $urandom_range(0, 1);
    id_uses_rs2_i = $urandom_range(0, 1);
    flush_i       = ($urandom_range(0, 99) < 10);
    ex_stall_i    = ($urandom_range(0, 99) < 15);
  endtask

  ctrl_t c_lw, c_add, c_sw, c_alu;
  int unsigned s0, f0;

  initial begin
    c_lw = CTRL_NOP;  c_lw.data_read = 1; c_lw.write_en_rf = 1; c_lw.load_type = 3'd2;
    c_add = CTRL_NOP; c_add.write_en_rf = 1; c_add.alu_op = 5'd1;
    c_sw = CTRL_NOP;  c_sw.write_en_dmem = 1; c_sw.store_type = 2'd2;
    c_alu = CTRL_NOP; c_alu.write_en_rf = 1; c_alu.alu_op = 5'd3;

    idle_inputs();
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_valid", 200'(ex_valid_o), 200'(0));
    chk("reset_ctrl", 200'(ex_ctrl_o), 200'(0));
    chk("reset_stall", 200'(stall_o), 200'(0));
    @(negedge clk);
    rst_n = 1;

    // Load followed by a dependent add: one bubble, then the add.
    instr(32'h100, c_lw, 5'd1, 1, 5'd2, 0, 5'd5);
    cycle();
    instr(32'h104, c_add, 5'd5, 1, 5'd1, 1, 5'd6);
    #1 chk("lu_stall", 200'(stall_o), 200'(1));
    cycle();
    chk("lu_bubble_valid", 200'(ex_valid_o), 200'(0));
    chk("lu_bubble_ctrl", 200'(ex_ctrl_o), 200'(0));
    #1 chk("lu_stall_one_cycle", 200'(stall_o), 200'(0));
    cycle();
    chk("lu_add_valid", 200'(ex_valid_o), 200'(1));
    chk("lu_add_rd", 200'(ex_rd_addr_o), 200'(6));
    chk("lu_add_pc", 200'(ex_pc_o), 200'(32'h104));

    // Load to x0 does not create a hazard for a reader of x0.
    instr(32'h200, c_lw, 5'd1, 1, 5'd0, 0, 5'd0);
    cycle();
    instr(32'h204, c_add, 5'd0, 1, 5'd0, 0, 5'd7);
    #1 chk("x0_no_stall", 200'(stall_o), 200'(0));
    cycle();
    chk("x0_capture_rd", 200'(ex_rd_addr_o), 200'(7));

    // Flush kills a store in decode.
    instr(32'h300, c_sw, 5'd2, 1, 5'd3, 1, 5'd0);
    flush_i = 1;
    cycle();
    flush_i = 0;
    chk("flush_valid", 200'(ex_valid_o), 200'(0));
    chk("flush_wen_dmem", 200'(ex_ctrl_o.write_en_dmem), 200'(0));

    // Three-cycle downstream stall with a flush in the middle cycle.
    instr(32'h400, c_alu, 5'd1, 1, 5'd2, 1, 5'd3);
    cycle();
    instr(32'h404, c_alu, 5'd4, 1, 5'd4, 0, 5'd8);
    ex_stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      flush_i = (i == 1);
      cycle();
      chk("stall_hold_pc", 200'(ex_pc_o), 200'(32'h400));
      chk("stall_hold_valid", 200'(ex_valid_o), 200'(1));
    end
    flush_i = 0;
    ex_stall_i = 0;
    cycle();
    chk("pend_bubble_valid", 200'(ex_valid_o), 200'(0));
    chk("pend_bubble_pc", 200'(ex_pc_o), 200'(0));
    cycle();
    chk("pend_cleared_pc", 200'(ex_pc_o), 200'(32'h404));

    // Load-use together with a flush: flush wins, no stall.
    instr(32'h500, c_lw, 5'd1, 1, 5'd2, 0, 5'd9);
    cycle();
    instr(32'h504, c_add, 5'd9, 1, 5'd1, 1, 5'd10);
    flush_i = 1;
    #1 chk("lu_flush_stall", 200'(stall_o), 200'(0));
`ifdef ID_EX_PERF_CNT_EN
    s0 = stall_cnt_o; f0 = flush_cnt_o;
`endif
    cycle();
    flush_i = 0;
    chk("lu_flush_valid", 200'(ex_valid_o), 200'(0));
`ifdef ID_EX_PERF_CNT_EN
    chk("lu_flush_fcnt", 200'(flush_cnt_o), 200'(f0 + 1));
    chk("lu_flush_scnt", 200'(stall_cnt_o), 200'(s0));
`endif

    // Asynchronous reset between edges with a flush owed.
    instr(32'h600, c_alu, 5'd1, 1, 5'd2, 0, 5'd11);
    cycle();
    ex_stall_i = 1; flush_i = 1;
    cycle();
    ex_stall_i = 0; flush_i = 0;
    instr(32'h604, c_alu, 5'd1, 1, 5'd2, 0, 5'd12);
    #1 rst_n = 0;
    #1;
    chk("areset_valid", 200'(ex_valid_o), 200'(0));
    chk("areset_pc", 200'(ex_pc_o), 200'(0));
    chk("areset_ctrl", 200'(ex_ctrl_o), 200'(0));
    chk("areset_rd", 200'(ex_rd_addr_o), 200'(0));
    chk("areset_stall", 200'(stall_o), 200'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    cycle();
    chk("areset_pend_lost", 200'(ex_pc_o), 200'(32'h604));

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
